cve2_alu_sequencer: RTL
=======================

// Module: cve2_alu_sequencer
// PURPOSE
//   Shares one cve2_alu instance between two requesters (req0, req1) and sequences each operation on it.
//   Round-robin arbitration; single-cycle and two-cycle (RV32B) ops.
//   Owns the ALU's intermediate-value registers (imd_val_q) and the first-cycle flag.
//   Returns result and comparison bit to the winner over a valid/ready response channel.
// PARAMETERS
//   RV32B  cve2_pkg::RV32BNone  bitmanip config; must match the ALU's RV32B; sets op cycle counts
// PORTS
//   clk_i                  in   1     clock
//   rst_i                  in   1     reset, synchronous, active-high
//   req0_valid_i/req1_valid_i   in   1   request valid
//   req0_ready_o/req1_ready_o   out  1   request accepted (grant) this cycle
//   req0_operator_i/req1_operator_i  in  alu_op_e  operation
//   req0_operand_a_i/req1_operand_a_i  in  32  operand A
//   req0_operand_b_i/req1_operand_b_i  in  32  operand B
//   rsp_valid_o            out  1     response valid
//   rsp_ready_i            in   1     response accepted
//   rsp_id_o               out  1     requester index of the response
//   rsp_result_o           out  32    captured alu result_o
//   rsp_cmp_o              out  1     captured alu comparison_result_o
//   busy_o                 out  1     FSM not in IDLE
//   alu_operator_o         out  alu_op_e  to ALU operator_i
//   alu_operand_a_o/alu_operand_b_o  out  32  to ALU operand_a_i / operand_b_i
//   alu_instr_first_cycle_o  out  1   to ALU instr_first_cycle_i
//   alu_multdiv_sel_o      out  1     tied 0; multdiv_operand_a/b driven 0 (33 b each)
//   alu_imd_val_q_o[2]     out  2x32  to ALU imd_val_q_i
//   alu_imd_val_d_i[2]     in   2x32  from ALU imd_val_d_o
//   alu_imd_val_we_i       in   2     from ALU imd_val_we_o
//   alu_result_i           in   32    from ALU result_o
//   alu_cmp_i              in   1     from ALU comparison_result_o
// BEHAVIOUR
//   Reset: state=IDLE; rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, rsp_cmp_o=0.
//     Also: busy_o=0, op/operand regs=0, imd_val regs=0, cnt=0, last_grant=1 (req0 wins first tie).
//   Reset mid-operation: in-flight op is dropped silently; no response is ever emitted for it.
//   FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: arbitrate among valid requests; grant = the other index if last_grant's index also requests.
//     readyN_o=1 only for the granted N, only in IDLE (combinational from valid and last_grant).
//     On grant: latch operator/operands and id; set last_grant=id; clear imd_val regs; set cnt=0.
//     Then go to EXEC.
//   EXEC: alu_* outputs driven from the latched regs, stable for the whole op.
//     alu_instr_first_cycle_o=1 only when cnt==0.
//     imd_val reg[i] <= alu_imd_val_d_i[i] in any EXEC cycle where alu_imd_val_we_i[i]=1.
//     When cnt==ncyc-1: capture alu_result_i and alu_cmp_i into rsp regs, go to RESP; else cnt++.
//   ncyc = alu_op_cycles(RV32B, op).
//     2 for ALU_ROL, ALU_ROR, ALU_FSL, ALU_FSR, ALU_CMIX, ALU_CMOV when RV32B!=RV32BNone.
//     1 otherwise.
//   RESP: rsp_valid_o=1; rsp_* stays stable until rsp_ready_i=1, then go to IDLE.
//     No grant is made in RESP.
//   Latency (grant cycle = T): rsp_valid_o rises at T+1+ncyc.
//     Minimum issue interval is 2+ncyc cycles.
//   alu_* outputs hold their last latched values in IDLE and RESP.
//     alu_instr_first_cycle_o=0 outside EXEC.
//   Request inputs are ignored outside IDLE.
//     A requester must hold valid and its payload until it sees ready.
//   busy_o = (state != IDLE).
// STRUCTURE
//   cve2_pkg additions: alu_seq_state_e {ALU_SEQ_IDLE, ALU_SEQ_EXEC, ALU_SEQ_RESP}.
//   cve2_pkg additions: function alu_op_cycles(rv32b_e, alu_op_e), returns 2 bits.
//   Sub-module cve2_alu_seq_arb: 2-way round-robin arbiter.
//     Inputs: valid[1:0], last_grant, en. Outputs: gnt[1:0], gnt_id.
//   Top level holds the FSM, counter, operand/imd_val/response regs.
//   The bench instantiates the sequencer alongside cve2_alu.
// TESTING
//   1) req0 ALU_ADD a=5 b=7 alone -> ready0 at T; rsp_valid at T+2, id=0, result=12; busy_o=0 after accept.
//   2) req0 and req1 both valid after reset, with req1 ALU_SUB a=10 b=3:
//      -> req0 granted first; after its accept, req1 granted; rsp_id=1, result=7.
//      Next simultaneous request -> req0 granted.
//   3) RV32B=RV32BBalanced, req1 ALU_ROR a=32'h0000_00F1 b=4 -> first_cycle high 1 cycle only.
//      -> imd_val written as ALU commands; rsp at T+3, result=32'h1000_000F.
//   4) ALU_LT a=32'hFFFF_FFFF b=1 -> rsp_cmp=1.
//      Hold rsp_ready=0 for 5 cycles -> rsp_* stable, req0_ready stays 0 while req0 valid.
//   5) rst_i asserted in the EXEC cycle of an ALU_ROR -> next cycle all outputs at reset values.
//      No response appears; a fresh ALU_ADD 1+1 then returns 2.
//   6) RV32B=RV32BNone, ALU_ROR -> ncyc=1; rsp at T+2.

Source files
------------

// File: rtl/cve2_alu_sequencer_pkg.sv
// Shared types for the ALU sequencer slice.
//   rv32b_e         : bitmanip configuration of the attached ALU
//   alu_op_e        : ALU operation encoding
//   alu_seq_state_e : sequencer FSM states
//   alu_op_cycles() : number of ALU cycles an operation occupies
package cve2_alu_sequencer_pkg;

  typedef enum logic [1:0] {
    RV32BNone,
    RV32BBalanced,
    RV32BOTEarlGrey,
    RV32BFull
  } rv32b_e;

  typedef enum logic [6:0] {
    ALU_ADD, ALU_SUB,
    ALU_XOR, ALU_OR, ALU_AND, ALU_XNOR, ALU_ORN, ALU_ANDN,
    ALU_SRA, ALU_SRL, ALU_SLL, ALU_SRO, ALU_SLO, ALU_ROR, ALU_ROL,
    ALU_LT, ALU_LTU, ALU_GE, ALU_GEU, ALU_EQ, ALU_NE, ALU_SLT, ALU_SLTU,
    ALU_FSL, ALU_FSR, ALU_CMIX, ALU_CMOV
  } alu_op_e;

  typedef enum logic [1:0] {
    ALU_SEQ_IDLE,
    ALU_SEQ_EXEC,
    ALU_SEQ_RESP
  } alu_seq_state_e;

  // Rotates, funnel shifts, cmix and cmov take a second cycle whenever
  // bitmanip is built in; everything else completes in one cycle.
  function automatic logic [1:0] alu_op_cycles(rv32b_e rv32b, alu_op_e op);
    logic [1:0] ncyc;
    ncyc = 2'd1;
    if (rv32b != RV32BNone) begin
      case (op)
        ALU_ROL, ALU_ROR, ALU_FSL, ALU_FSR, ALU_CMIX, ALU_CMOV: ncyc = 2'd2;
        default: ncyc = 2'd1;
      endcase
    end
    return ncyc;
  endfunction

endpackage

// File: rtl/cve2_alu_seq_arb.sv
// Two-way round-robin arbiter for the ALU sequencer.
//   valid[1:0] : pending requests
//   last_grant : index granted most recently
//   en         : arbitration allowed this cycle
//   gnt[1:0]   : one-hot grant (zero when disabled or nothing valid)
//   gnt_id     : index of the winner (meaningful only when gnt != 0)
module cve2_alu_seq_arb (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // On a tie the requester that did not win last time goes first.
  assign gnt_id = (&valid) ? ~last_grant : valid[1];
  assign gnt    = {gnt_id, ~gnt_id} & {2{en & (|valid)}};

endmodule

// File: rtl/cve2_alu_sequencer.sv
// Shares one ALU between two requesters and sequences single- and
// two-cycle operations on it, returning result and compare bit over a
// valid/ready response channel.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   reqN_*                   : request channel per requester (valid/ready/op/operands)
//   rsp_*                    : response channel (valid/ready/id/result/cmp)
//   busy_o                   : operation in flight or response pending
//   alu_*                    : connection to the shared ALU instance
//
// state | meaning
// IDLE  | arbitrating; grant latches op/operands/id
// EXEC  | ALU running the latched op; cnt counts its cycles
// RESP  | response held on rsp_* until rsp_ready_i
module cve2_alu_sequencer
  import cve2_alu_sequencer_pkg::*;
#(
  parameter rv32b_e RV32B = RV32BNone
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_valid_i,
  input  logic          req1_valid_i,
  output logic          req0_ready_o,
  output logic          req1_ready_o,
  input  alu_op_e       req0_operator_i,
  input  alu_op_e       req1_operator_i,
  input  logic [31:0]   req0_operand_a_i,
  input  logic [31:0]   req1_operand_a_i,
  input  logic [31:0]   req0_operand_b_i,
  input  logic [31:0]   req1_operand_b_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic          rsp_id_o,
  output logic [31:0]   rsp_result_o,
  output logic          rsp_cmp_o,
  output logic          busy_o,
  output alu_op_e       alu_operator_o,
  output logic [31:0]   alu_operand_a_o,
  output logic [31:0]   alu_operand_b_o,
  output logic          alu_instr_first_cycle_o,
  output logic          alu_multdiv_sel_o,
  output logic [32:0]   alu_multdiv_operand_a_o,
  output logic [32:0]   alu_multdiv_operand_b_o,
  output logic [31:0]   alu_imd_val_q_o [2],
  input  logic [31:0]   alu_imd_val_d_i [2],
  input  logic [1:0]    alu_imd_val_we_i,
  input  logic [31:0]   alu_result_i,
  input  logic          alu_cmp_i
);

  alu_seq_state_e state_q, state_d;
  alu_op_e        op_q;
  logic [31:0]    operand_a_q, operand_b_q;
  logic [31:0]    imd_val_q [2];
  logic [1:0]     cnt_q;
  logic           id_q, last_grant_q;
  logic [31:0]    result_q;
  logic           cmp_q;

  logic [1:0]     gnt;
  logic           gnt_id;
  logic [1:0]     ncyc;
  logic           exec_last;

  cve2_alu_seq_arb u_arb (
    .valid      ({req1_valid_i, req0_valid_i}),
    .last_grant (last_grant_q),
    .en         (state_q == ALU_SEQ_IDLE),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  assign ncyc      = alu_op_cycles(RV32B, op_q);
  assign exec_last = (cnt_q == (ncyc - 2'd1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ALU_SEQ_IDLE: if (|gnt) state_d = ALU_SEQ_EXEC;
      ALU_SEQ_EXEC: if (exec_last) state_d = ALU_SEQ_RESP;
      ALU_SEQ_RESP: if (rsp_ready_i) state_d = ALU_SEQ_IDLE;
      default:      state_d = ALU_SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ALU_SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset mid-operation simply discards everything, so an interrupted op
  // can never surface as a response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q         <= ALU_ADD;
      operand_a_q  <= '0;
      operand_b_q  <= '0;
      imd_val_q[0] <= '0;
      imd_val_q[1] <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      cmp_q        <= 1'b0;
    end else begin
      case (state_q)
        ALU_SEQ_IDLE: begin
          if (|gnt) begin
            id_q         <= gnt_id;
            last_grant_q <= gnt_id;
            op_q         <= gnt_id ? req1_operator_i  : req0_operator_i;
            operand_a_q  <= gnt_id ? req1_operand_a_i : req0_operand_a_i;
            operand_b_q  <= gnt_id ? req1_operand_b_i : req0_operand_b_i;
            imd_val_q[0] <= '0;
            imd_val_q[1] <= '0;
            cnt_q        <= '0;
          end
        end
        ALU_SEQ_EXEC: begin
          for (int i = 0; i < 2; i++) begin
            if (alu_imd_val_we_i[i]) imd_val_q[i] <= alu_imd_val_d_i[i];
          end
          if (exec_last) begin
            result_q <= alu_result_i;
            cmp_q    <= alu_cmp_i;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];

  assign rsp_valid_o  = (state_q == ALU_SEQ_RESP);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = result_q;
  assign rsp_cmp_o    = cmp_q;
  assign busy_o       = (state_q != ALU_SEQ_IDLE);

  assign alu_operator_o          = op_q;
  assign alu_operand_a_o         = operand_a_q;
  assign alu_operand_b_o         = operand_b_q;
  assign alu_instr_first_cycle_o = (state_q == ALU_SEQ_EXEC) && (cnt_q == 2'd0);
  assign alu_multdiv_sel_o       = 1'b0;
  assign alu_multdiv_operand_a_o = '0;
  assign alu_multdiv_operand_b_o = '0;
  assign alu_imd_val_q_o[0]      = imd_val_q[0];
  assign alu_imd_val_q_o[1]      = imd_val_q[1];

endmodule
